in_mem_rd_ctrl: RTL and testbench

IN_MEM_RD_CTRL -- requirements
Module: in_mem_rd_ctrl

---
 rtl/in_mem_rd_ctrl.sv | 154 +++++++++++++++
 tb/tb_in_mem_rd_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/in_mem_rd_ctrl.sv
// Input-memory read controller: streams one tile from SYS_ROW banks into the systolic array
// with diagonal skew. Define IN_MEM_RD_CFG_CHK_EN to enable start-time configuration checking.
module in_mem_rd_ctrl #(
    parameter int SYS_ROW    = 16,
    parameter int SYS_COL    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int ACCUM_SIZE = 1024
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic [DATA_WIDTH-1:0]          num_common,
    input  logic [31:0]                    num_rows,
    output logic [SYS_ROW-1:0]             in_rd_en,
    output logic [SYS_ROW*ADDR_WIDTH-1:0]  in_rd_addr,
    input  logic [SYS_ROW*DATA_WIDTH-1:0]  in_rd_data,
    output logic [SYS_ROW-1:0]             sa_in_valid,
    output logic [SYS_ROW*DATA_WIDTH-1:0]  sa_in_data,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_err
);

    localparam int          ACCUM_ROW = ACCUM_SIZE / SYS_COL;
    localparam int          LOG2_ROW  = $clog2(SYS_ROW);
    localparam int          ACC_SH    = $clog2(ACCUM_ROW);
    localparam int unsigned NLANE     = SYS_ROW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state;
    logic [31:0]             nc_q, rows_q, row_cnt, chunk_cnt, drain_cnt;
    logic [31:0]             nc_in, row_nxt, chunk_nxt;
    logic                    last_rd, zero_cfg, bad_cfg;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [SYS_ROW-1:0]      en_d1;

    always_comb begin
        nc_in    = 32'(num_common >> LOG2_ROW);
        zero_cfg = (nc_in == '0) || (num_rows == '0);
`ifdef IN_MEM_RD_CFG_CHK_EN
        bad_cfg  = ((num_common & DATA_WIDTH'(SYS_ROW - 1)) != '0) || (num_rows > 32'(ACCUM_ROW));
`else
        bad_cfg  = 1'b0;
`endif
        last_rd  = (row_cnt == rows_q - 1) && (chunk_cnt == nc_q - 1);
        if (row_cnt == rows_q - 1) begin
            row_nxt   = '0;
            chunk_nxt = chunk_cnt + 1;
        end else begin
            row_nxt   = row_cnt + 1;
            chunk_nxt = chunk_cnt;
        end
        addr_nxt = ADDR_WIDTH'((chunk_nxt << ACC_SH) + row_nxt);
    end

`ifdef IN_MEM_RD_CFG_CHK_EN
    logic cfg_err_q;
    assign cfg_err = cfg_err_q;
`else
    assign cfg_err = 1'b0;
`endif

    // Lane 0 is driven by the FSM; lanes 1.. follow through a shift chain whose
    // address stage only advances with a valid enable, so idle lanes hold their address.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            nc_q       <= '0;
            rows_q     <= '0;
            row_cnt    <= '0;
            chunk_cnt  <= '0;
            drain_cnt  <= '0;
            in_rd_en   <= '0;
            in_rd_addr <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef IN_MEM_RD_CFG_CHK_EN
            cfg_err_q  <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            in_rd_en <= {in_rd_en[SYS_ROW-2:0], 1'b0};
            for (int unsigned i = 1; i < NLANE; i++) begin
                if (in_rd_en[i-1])
                    in_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] <= in_rd_addr[(i-1)*ADDR_WIDTH +: ADDR_WIDTH];
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        nc_q      <= nc_in;
                        rows_q    <= num_rows;
                        row_cnt   <= '0;
                        chunk_cnt <= '0;
                        busy      <= 1'b1;
                        if (zero_cfg || bad_cfg) begin
                            state <= DONE;
                            done  <= 1'b1;
`ifdef IN_MEM_RD_CFG_CHK_EN
                            cfg_err_q <= bad_cfg;
`endif
                        end else begin
                            state                      <= RUN;
                            in_rd_en[0]                <= 1'b1;
                            in_rd_addr[ADDR_WIDTH-1:0] <= '0;
                        end
                    end
                end
                RUN: begin
                    if (last_rd) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        row_cnt                    <= row_nxt;
                        chunk_cnt                  <= chunk_nxt;
                        in_rd_en[0]                <= 1'b1;
                        in_rd_addr[ADDR_WIDTH-1:0] <= addr_nxt;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 32'(SYS_ROW)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
`ifdef IN_MEM_RD_CFG_CHK_EN
                    cfg_err_q <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_d1       <= '0;
            sa_in_valid <= '0;
            sa_in_data  <= '0;
        end else begin
            en_d1       <= in_rd_en;
            sa_in_valid <= en_d1;
            for (int unsigned i = 0; i < NLANE; i++)
                sa_in_data[i*DATA_WIDTH +: DATA_WIDTH] <= en_d1[i] ? in_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

endmodule

// File: tb/tb_in_mem_rd_ctrl.sv
// Self-checking bench for in_mem_rd_ctrl: a cycle-indexed model of the read schedule plus
// hand-computed pins for the documented scenarios.
module tb_in_mem_rd_ctrl;

    localparam int SR = 16;
    localparam int SC = 16;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int AS = 1024;
    localparam int AR = AS / SC;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start = 1'b0;
    logic [DW-1:0]     num_common = '0;
    logic [31:0]       num_rows = '0;
    logic [SR-1:0]     in_rd_en;
    logic [SR*AW-1:0]  in_rd_addr;
    logic [SR*DW-1:0]  in_rd_data = '0;
    logic [SR-1:0]     sa_in_valid;
    logic [SR*DW-1:0]  sa_in_data;
    logic              busy, done, cfg_err;

    in_mem_rd_ctrl #(
        .SYS_ROW(SR), .SYS_COL(SC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACCUM_SIZE(AS)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .num_common(num_common), .num_rows(num_rows),
        .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
        .sa_in_valid(sa_in_valid), .sa_in_data(sa_in_data),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    bit chk_on = 1'b0;

    // model state: start edge, read count, rows, done cycle
    bit            m_active = 1'b0;
    bit            m_cfg = 1'b0;
    int            m_S = 0, m_T = 0, m_R = 1, m_D = 0;
    logic [AW-1:0] m_addr [SR];

    function automatic logic [DW-1:0] memval(input int b, input logic [AW-1:0] a);
        return DW'(b * 16'h1111) ^ DW'(a * 5 + 3);
    endfunction

    function automatic logic [AW-1:0] idx_addr(input int j, input int r);
        return AW'((j / r) * AR + (j % r));
    endfunction

    function automatic logic [AW-1:0] lane_addr(input int i);
        return in_rd_addr[i*AW +: AW];
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // bank memories: registered read, data one cycle after enable
    always @(posedge clk)
        for (int i = 0; i < SR; i++)
            if (in_rd_en[i]) in_rd_data[i*DW +: DW] <= memval(i, in_rd_addr[i*AW +: AW]);

    always @(negedge clk) begin : cmp
        logic [SR-1:0]    e_en, e_val;
        logic [SR*AW-1:0] e_addr;
        logic [SR*DW-1:0] e_data;
        logic             e_busy, e_done, e_cfg;
        int               k, j;
        if (chk_on) begin
            e_en = '0; e_val = '0; e_addr = '0; e_data = '0;
            e_busy = 1'b0; e_done = 1'b0; e_cfg = 1'b0;
            if (!rstn) begin
                for (int i = 0; i < SR; i++) m_addr[i] = '0;
            end else begin
                k = edge_cnt - m_S + 1;
                for (int i = 0; i < SR; i++) begin
                    j = k - 1 - i;
                    if (m_active && j >= 0 && j < m_T) begin
                        e_en[i] = 1'b1;
                        m_addr[i] = idx_addr(j, m_R);
                    end
                    e_addr[i*AW +: AW] = m_addr[i];
                    j = k - 3 - i;
                    if (m_active && j >= 0 && j < m_T) begin
                        e_val[i] = 1'b1;
                        e_data[i*DW +: DW] = memval(i, idx_addr(j, m_R));
                    end
                end
                e_busy = m_active && k >= 1 && k <= m_D;
                e_done = m_active && k == m_D;
                e_cfg  = m_active && m_cfg && k == 1;
            end
            chk("rd_en", in_rd_en, e_en);
            chk("rd_addr", in_rd_addr, e_addr);
            chk("sa_valid", sa_in_valid, e_val);
            chk("sa_data", sa_in_data, e_data);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("cfg_err", cfg_err, e_cfg);
        end
    end

    // call at a negedge; returns at the negedge of cycle 1
    task automatic do_start(input int nc, input int nr);
        bit bad;
        int k;
        num_common = DW'(nc);
        num_rows   = nr;
        start      = 1'b1;
        k = edge_cnt - m_S + 1;
        if (!m_active || k > m_D) begin
            bad = 1'b0;
`ifdef IN_MEM_RD_CFG_CHK_EN
            bad = (nc % SR != 0) || (nr > AR);
`endif
            m_S = edge_cnt + 1;
            m_R = (nr > 0) ? nr : 1;
            m_T = bad ? 0 : (nc / SR) * nr;
            m_D = (m_T == 0) ? 1 : m_T + SR + 2;
            m_cfg = bad;
            m_active = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_k);
        for (int n = 0; n < 2000; n++) begin
            if (done === 1'b1) break;
            @(negedge clk);
        end
        chk(name, edge_cnt - m_S + 1, exp_k);
        repeat (2) @(negedge clk);
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b1;
        #2 rstn = 1'b0;
        chk_on = 1'b1;
        skip(2);
        chk("reset_outputs", {in_rd_en, busy, done, cfg_err, sa_in_valid}, '0);
        rstn = 1'b1;

        // nc=32 (NC=2), R=3: start on first edge after release
        do_start(32, 3);
        for (int k = 1; k <= 25; k++) begin
            case (k)
                1:  chk("r20_l0_c1", {in_rd_en[0], lane_addr(0)}, {1'b1, 16'd0});
                4:  chk("r20_l0_c4", {in_rd_en[0], lane_addr(0)}, {1'b1, 16'd64});
                6:  chk("r20_l0_c6", {in_rd_en[0], lane_addr(0)}, {1'b1, 16'd66});
                7:  chk("r20_l0_hold", {in_rd_en[0], lane_addr(0)}, {1'b0, 16'd66});
                15: chk("r20_l15_c15", in_rd_en[15], 1'b0);
                16: chk("r20_l15_c16", {in_rd_en[15], lane_addr(15)}, {1'b1, 16'd0});
                21: chk("r20_l15_c21", {in_rd_en[15], lane_addr(15)}, {1'b1, 16'd66});
                23: chk("r20_done_c23", done, 1'b0);
                24: chk("r20_done_c24", {done, busy}, 2'b11);
                25: chk("r20_idle_c25", {done, busy}, 2'b00);
                default: ;
            endcase
            if (k == 3) chk("r20_sa0_c3", {sa_in_valid[0], sa_in_data[DW-1:0]}, {1'b1, 16'h0003});
            @(negedge clk);
        end
        skip(2);

        // zero rows and NC==0 complete immediately
        do_start(32, 0);
        chk("r21_c1", {done, busy}, 2'b11);
        skip(1);
        chk("r21_c2", {done, busy}, 2'b00);
        skip(2);
        do_start(15, 4);
        wait_done("nc0_done", 1);

        // re-pulse during run is ignored
        do_start(32, 3);
        skip(2);
        do_start(32, 3);
        wait_done("r22_done", 24);

        // asynchronous reset mid-run
        do_start(32, 3);
        skip(2);
        @(posedge clk);
        #1 rstn = 1'b0;
        m_active = 1'b0;
        #1 chk("r23_async", {in_rd_en, in_rd_addr, sa_in_valid, sa_in_data, busy, done, cfg_err}, '0);
        skip(3);
        rstn = 1'b1;
        do_start(32, 3);
        skip(3);
        chk("r23_l0_c4", {in_rd_en[0], lane_addr(0)}, {1'b1, 16'd64});
        wait_done("r23_done", 24);

        // 64 rows: chunk boundary at ACCUM_ROW
        do_start(32, 64);
        skip(127);
        chk("r24_last_addr", {in_rd_en[0], lane_addr(0)}, {1'b1, 16'd127});
        wait_done("r24_done", 146);

        // single row per chunk: chunk advances every cycle
        do_start(48, 1);
        skip(2);
        chk("r1_c3_addr", {in_rd_en[0], lane_addr(0)}, {1'b1, 16'd128});
        wait_done("r1_done", 21);

        // num_common not a multiple of SYS_ROW
        do_start(24, 5);
`ifdef IN_MEM_RD_CFG_CHK_EN
        chk("r25_cfg_c1", {cfg_err, done, in_rd_en[0]}, 3'b110);
        wait_done("r25_done", 1);
`else
        chk("r25_cfg_c1", {cfg_err, done, in_rd_en[0]}, 3'b001);
        wait_done("r25_done", 23);
`endif

        skip(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
